spi_regfile_rw: RTL and testbench

SPI_REGFILE_RW -- requirements
Module: spi_regfile_rw

---
 rtl/spi_regfile_rw.sv | 166 ++++++++++++++++
 tb/tb_spi_regfile_rw.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_rw.sv
// SPI mode-0 slave exposing five 8-bit control registers plus a read-only error counter.
// Every SPI input is resynchronised into clk; the frame is committed as a whole when ncs rises.
module spi_regfile_rw (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       ncs,
  input  logic       copi,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e          state_q, state_d;
  logic [2:0]      sclk_pipe_q, sclk_pipe_d;
  logic [2:0]      ncs_pipe_q, ncs_pipe_d;
  logic [1:0]      copi_pipe_q, copi_pipe_d;
  logic [15:0]     shift_q, shift_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [7:0]      out_q, out_d;
  logic            rd_q, rd_d;
  logic [4:0][7:0] regs_q, regs_d;
  logic [7:0]      err_cnt_q, err_cnt_d;
  logic            frame_err_q, frame_err_d;

  logic       sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_s, copi_s;
  logic [6:0] rd_addr, wr_addr;
  logic [7:0] rd_data;

  // Index 1 is the synchronised level, index 2 the delayed copy used for edge detection.
  assign sclk_rise = sclk_pipe_q[1] & ~sclk_pipe_q[2];
  assign sclk_fall = ~sclk_pipe_q[1] & sclk_pipe_q[2];
  assign ncs_rise  = ncs_pipe_q[1] & ~ncs_pipe_q[2];
  assign ncs_fall  = ~ncs_pipe_q[1] & ncs_pipe_q[2];
  assign ncs_s     = ncs_pipe_q[1];
  assign copi_s    = copi_pipe_q[1];

  // After eight bits the header sits in shift_q[7:0]; at commit it sits in shift_q[15:8].
  assign rd_addr = shift_q[6:0];
  assign wr_addr = shift_q[14:8];

  always_comb begin
    rd_data = 8'h00;
    unique case (rd_addr)
      7'd0:    rd_data = regs_q[0];
      7'd1:    rd_data = regs_q[1];
      7'd2:    rd_data = regs_q[2];
      7'd3:    rd_data = regs_q[3];
      7'd4:    rd_data = regs_q[4];
      7'd5:    rd_data = err_cnt_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sclk_pipe_d = {sclk_pipe_q[1:0], sclk};
    ncs_pipe_d  = {ncs_pipe_q[1:0], ncs};
    copi_pipe_d = {copi_pipe_q[0], copi};
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    rd_d        = rd_q;
    regs_d      = regs_q;
    err_cnt_d   = err_cnt_q;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          state_d = StShift;
          shift_d = 16'h0000;
          cnt_d   = 5'd0;
          out_d   = 8'h00;
          rd_d    = 1'b0;
        end
      end
      StShift: begin
        if (ncs_rise) begin
          state_d = StCommit;
        end else if (!ncs_s) begin
          if (sclk_rise) begin
            shift_d = {shift_q[14:0], copi_s};
            if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
          end
          if (sclk_fall) begin
            if (cnt_q == 5'd8 && !shift_q[7]) begin
              out_d = rd_data;
              rd_d  = 1'b1;
            end else if (rd_q && cnt_q >= 5'd9) begin
              out_d = {out_q[6:0], 1'b0};
            end
          end
        end
      end
      StCommit: begin
        state_d = StIdle;
        if (cnt_q != 5'd16) begin
          frame_err_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else if (shift_q[15]) begin
          unique case (wr_addr)
            7'd0:    regs_d[0] = shift_q[7:0];
            7'd1:    regs_d[1] = shift_q[7:0];
            7'd2:    regs_d[2] = shift_q[7:0];
            7'd3:    regs_d[3] = shift_q[7:0];
            7'd4:    regs_d[4] = shift_q[7:0];
            default: ;
          endcase
        end
        // A back-to-back frame may already have started; do not drop its ncs fall.
        if (ncs_fall) begin
          state_d = StShift;
          shift_d = 16'h0000;
          cnt_d   = 5'd0;
          out_d   = 8'h00;
          rd_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sclk_pipe_q <= 3'b000;
      ncs_pipe_q  <= 3'b000;
      copi_pipe_q <= 2'b00;
      shift_q     <= 16'h0000;
      cnt_q       <= 5'd0;
      out_q       <= 8'h00;
      rd_q        <= 1'b0;
      regs_q      <= '0;
      err_cnt_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_pipe_q <= sclk_pipe_d;
      ncs_pipe_q  <= ncs_pipe_d;
      copi_pipe_q <= copi_pipe_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      rd_q        <= rd_d;
      regs_q      <= regs_d;
      err_cnt_q   <= err_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign cipo            = (state_q == StShift) && !ncs_s && rd_q && out_q[7];
  assign frame_err       = frame_err_q;
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];

endmodule

// File: tb/tb_spi_regfile_rw.sv
// Directed bench for spi_regfile_rw: writes, read-back over cipo, aborted frames,
// ignored addresses and reset in the middle of a frame.
module tb_spi_regfile_rw;

  logic       clk, rst_n, sclk, ncs, copi;
  logic       cipo, frame_err;
  logic [7:0] r0, r1, r2, r3, r4;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_count = 0;

  spi_regfile_rw dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .ncs             (ncs),
    .copi            (copi),
    .cipo            (cipo),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .frame_err       (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts clk cycles with frame_err high, so one clean pulse adds exactly one.
  always @(posedge clk) if (frame_err === 1'b1) fe_count++;

  // sclk period is 10 clk; rst_after > 0 pulses rst_n low after that many bits.
  task automatic spi_frame(input logic [15:0] tx, input int nbits, input int rst_after,
                           output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge clk);
    ncs = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      copi = tx[15-i];
      #50;
      sclk = 1'b1;
      rx[15-i] = cipo;
      #50;
      sclk = 1'b0;
      if (i + 1 == rst_after) begin
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
      end
    end
    #50;
    ncs  = 1'b1;
    copi = 1'b0;
  endtask

  task automatic check_regs(input string name, input logic [39:0] exp);
    n_checks++;
    if ({r0, r1, r2, r3, r4} !== exp) begin
      n_fail++;
      $display("FAIL %s: regs got %h expected %h", name, {r0, r1, r2, r3, r4}, exp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sclk = 1'b0; ncs = 1'b1; copi = 1'b0;
    #22;
    check_regs("reset_asserted", 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_regs("reset_idle", 40'h0);
    n_checks++;
    if (cipo !== 1'b0) begin n_fail++; $display("FAIL reset_cipo: got %b expected 0", cipo); end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
  endtask

  task automatic test_write_pwm;
    logic [15:0] rx;
    spi_frame(16'h8455, 16, 0, rx);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (r4 !== 8'h55) begin n_fail++; $display("FAIL pwm_latency: got %h expected 55", r4); end
    #200;
    check_regs("pwm_others", 40'h00_00_00_00_55);
    n_checks++;
    if (fe_count !== 0) begin n_fail++; $display("FAIL pwm_no_err: got %0d expected 0", fe_count); end
  endtask

  task automatic test_read_back;
    logic [15:0] rx;
    spi_frame(16'h80F0, 16, 0, rx);
    #300;
    spi_frame(16'h0000, 16, 0, rx);
    n_checks++;
    if (rx[7:0] !== 8'hF0) begin n_fail++; $display("FAIL read_data: got %h expected f0", rx[7:0]); end
    n_checks++;
    if (rx[15:8] !== 8'h00) begin
      n_fail++; $display("FAIL read_header_cipo: got %h expected 00", rx[15:8]);
    end
    #300;
    check_regs("read_no_modify", 40'hF0_00_00_00_55);
    n_checks++;
    if (cipo !== 1'b0) begin n_fail++; $display("FAIL cipo_idle: got %b expected 0", cipo); end
  endtask

  task automatic test_short_frame;
    logic [15:0] rx;
    spi_frame(16'h81FF, 12, 0, rx);
    #300;
    n_checks++;
    if (fe_count !== 1) begin n_fail++; $display("FAIL short_err_pulse: got %0d expected 1", fe_count); end
    check_regs("short_no_write", 40'hF0_00_00_00_55);
    spi_frame(16'h0500, 16, 0, rx);
    n_checks++;
    if (rx[7:0] !== 8'h01) begin n_fail++; $display("FAIL err_cnt_read: got %h expected 01", rx[7:0]); end
    #300;
    n_checks++;
    if (fe_count !== 1) begin n_fail++; $display("FAIL read_no_err: got %0d expected 1", fe_count); end
  endtask

  task automatic test_ignored_addr;
    logic [15:0] rx;
    spi_frame(16'h87AA, 16, 0, rx);
    #300;
    check_regs("addr7_ignored", 40'hF0_00_00_00_55);
    n_checks++;
    if (fe_count !== 1) begin n_fail++; $display("FAIL addr7_no_err: got %0d expected 1", fe_count); end
    spi_frame(16'h0700, 16, 0, rx);
    n_checks++;
    if (rx[7:0] !== 8'h00) begin n_fail++; $display("FAIL addr7_read: got %h expected 00", rx[7:0]); end
    #300;
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] rx;
    int fe_before;
    spi_frame(16'h81FF, 16, 10, rx);
    fe_before = fe_count;
    #300;
    check_regs("mid_reset_cleared", 40'h0);
    n_checks++;
    if (fe_count !== fe_before) begin
      n_fail++; $display("FAIL mid_reset_no_err: got %0d expected %0d", fe_count, fe_before);
    end
    spi_frame(16'h81FF, 16, 0, rx);
    #300;
    check_regs("post_reset_write", 40'h00_FF_00_00_00);
    spi_frame(16'h0500, 16, 0, rx);
    n_checks++;
    if (rx[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL err_cnt_after_reset: got %h expected 00", rx[7:0]);
    end
    #300;
  endtask

  initial begin
    test_reset();
    test_write_pwm();
    test_read_back();
    test_short_frame();
    test_ignored_addr();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
